// File: rtl/ifetch_if.sv
// ifetch_if: fetch-side memory request/response, redirect and decode handshake bundle
interface ifetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, InstrD, PCD, PCPlus4D,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, InstrD, PCD, PCPlus4D,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential fetch with in-order response queue, PC tagging and redirect flush
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic      clk,
    input logic      reset,
    ifetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   pc_f;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   pf_pc   [DEPTH];
    logic [AW-1:0] q_head, q_tail, pf_head, pf_tail;
    logic [AW:0]   count, outstanding, drop;
    logic [AW+1:0] inflight;
    logic          accept, resp, push, pop;
    always_comb begin
        inflight           = (AW+2)'(count) + (AW+2)'(outstanding);
        bus.imem_req_valid = !reset && !bus.redirect_valid && (inflight < (AW+2)'(DEPTH));
        bus.imem_req_addr  = pc_f;
        bus.instr_valid    = count != 0;
        bus.InstrD         = bus.instr_valid ? q_instr[q_head] : 32'd0;
        bus.PCD            = bus.instr_valid ? q_pc[q_head] : 32'd0;
        bus.PCPlus4D       = bus.PCD + 32'd4;
        accept             = bus.imem_req_valid && bus.imem_req_ready;
        resp               = bus.imem_resp_valid && outstanding != 0;
        push               = resp && drop == 0 && !bus.redirect_valid;
        pop                = bus.instr_valid && bus.instr_ready;
    end
    // Storage needs no reset: entries are only read once count/outstanding cover them
    always_ff @(posedge clk) begin
        if (accept) pf_pc[pf_tail] <= pc_f;
        if (push) begin
            q_instr[q_tail] <= bus.imem_resp_data;
            q_pc[q_tail]    <= pf_pc[pf_head];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            q_head      <= '0;
            q_tail      <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            pf_tail     <= pf_tail + AW'(accept);
            pf_head     <= pf_head + AW'(resp);
            outstanding <= outstanding + (AW+1)'(accept) - (AW+1)'(resp);
            if (bus.redirect_valid) begin
                pc_f   <= {bus.redirect_pc[31:2], 2'b00};
                q_head <= '0;
                q_tail <= '0;
                count  <= '0;
                drop   <= outstanding - (AW+1)'(resp);
            end else begin
                pc_f   <= accept ? pc_f + 32'd4 : pc_f;
                q_head <= q_head + AW'(pop);
                q_tail <= q_tail + AW'(push);
                count  <= count + (AW+1)'(push) - (AW+1)'(pop);
                drop   <= drop - (AW+1)'(resp && drop != 0);
            end
        end
    end
endmodule
